// File: rtl/chrono_pkg.sv
// Shared types for the stopwatch time base: FSM states, time field widths and limits,
// and the one-tick increment with its full carry chain.
package chrono_pkg;

  localparam int HOURS_W       = 4;
  localparam int MIN_W         = 6;
  localparam int SEC_W         = 6;
  localparam int MS_W          = 10;
  localparam int MIN_MAX       = 59;
  localparam int SEC_MAX       = 59;
  localparam int MS_MAX        = 999;
  localparam int HOURS_MAX_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_PAUSE    = 2'd2,
    ST_LAP_HOLD = 2'd3
  } state_t;

  typedef struct packed {
    logic [HOURS_W-1:0] hours;
    logic [MIN_W-1:0]   minutes;
    logic [SEC_W-1:0]   seconds;
    logic [MS_W-1:0]    ms;
  } chrono_time_t;

  // True when the next tick wraps every field back to zero.
  function automatic logic time_last(chrono_time_t t, int hours_max);
    return (t.hours == HOURS_W'(hours_max)) && (t.minutes == MIN_W'(MIN_MAX)) &&
           (t.seconds == SEC_W'(SEC_MAX)) && (t.ms == MS_W'(MS_MAX));
  endfunction

  function automatic chrono_time_t time_inc(chrono_time_t t, int hours_max);
    chrono_time_t r;
    r = t;
    if (t.ms != MS_W'(MS_MAX)) begin
      r.ms = t.ms + 1'b1;
    end else begin
      r.ms = '0;
      if (t.seconds != SEC_W'(SEC_MAX)) begin
        r.seconds = t.seconds + 1'b1;
      end else begin
        r.seconds = '0;
        if (t.minutes != MIN_W'(MIN_MAX)) begin
          r.minutes = t.minutes + 1'b1;
        end else begin
          r.minutes = '0;
          r.hours   = (t.hours == HOURS_W'(hours_max)) ? '0 : t.hours + 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/chrono_counter_if.sv
// Button pulses and time load in, displayed time and status out.
// master = controller/bench, slave = chrono_counter.
interface chrono_counter_if;
  import chrono_pkg::*;

  logic               start_stop;
  logic               clear;
  logic               lap;
  logic               preset;
  chrono_time_t       preset_time;
  logic [HOURS_W-1:0] hours;
  logic [MIN_W-1:0]   minutes;
  logic [SEC_W-1:0]   seconds;
  logic [MS_W-1:0]    milliseconds;
  logic               running;
  logic               overflow;
  logic               update;

  modport master (
    output start_stop, clear, lap, preset, preset_time,
    input  hours, minutes, seconds, milliseconds, running, overflow, update
  );

  modport slave (
    input  start_stop, clear, lap, preset, preset_time,
    output hours, minutes, seconds, milliseconds, running, overflow, update
  );

endinterface

// File: rtl/ms_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled, flags tick on the last count.
// Latency: tick is a decode of the count register, consumed on the same edge.
// Backpressure: none; holds its count while disabled, clr forces zero.
module ms_tick_gen #(
  parameter int TICK_DIV = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/chrono_counter.sv
// Stopwatch time base (h:m:s.ms) from a 1 ms tick; lap hold under CHRONO_LAP_EN.
// Latency: all outputs registered; a tick is visible right after the edge it occurs on.
// Backpressure: none; clear > start_stop > lap for coincident pulses.
module chrono_counter
  import chrono_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_DIV    = CLK_FREQ_HZ / 1000,
  parameter int HOURS_MAX   = HOURS_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset,
  chrono_counter_if.slave  bus
);

  state_t       state_q, state_d;
  logic         cnt_en, running_d, running_q;
  logic         tick;
  chrono_time_t time_q, time_d;
  logic         ovf_q, ovf_d;
  chrono_time_t disp_now, disp_d;
  logic         upd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
    end else if (bus.start_stop) begin
      case (state_q)
        ST_RUN, ST_LAP_HOLD: state_d = ST_PAUSE;
        default:             state_d = ST_RUN;
      endcase
    end
`ifdef CHRONO_LAP_EN
    else if (bus.lap) begin
      case (state_q)
        ST_RUN:      state_d = ST_LAP_HOLD;
        ST_LAP_HOLD: state_d = ST_RUN;
        default:     state_d = state_q;
      endcase
    end
`endif
  end

  always_comb begin
    cnt_en    = (state_q == ST_RUN) || (state_q == ST_LAP_HOLD);
    running_d = (state_d == ST_RUN) || (state_d == ST_LAP_HOLD);
  end

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clr   (bus.clear),
    .tick  (tick)
  );

  // preset is a bring-up time load; it leaves state and sub-ms phase alone.
  always_comb begin
    time_d = time_q;
    ovf_d  = ovf_q;
    if (bus.clear) begin
      time_d = '0;
      ovf_d  = 1'b0;
    end else if (bus.preset) begin
      time_d = bus.preset_time;
    end else if (tick) begin
      time_d = time_inc(time_q, HOURS_MAX);
      if (time_last(time_q, HOURS_MAX)) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q    <= '0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      time_q    <= time_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
      upd_q     <= (disp_d != disp_now);
    end
  end

`ifdef CHRONO_LAP_EN
  chrono_time_t disp_q;

  // Display freezes while in (or entering) LAP_HOLD and follows internal time otherwise.
  always_comb begin
    disp_d = disp_q;
    if (bus.clear)                  disp_d = '0;
    else if (state_d != ST_LAP_HOLD) disp_d = time_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) disp_q <= '0;
    else       disp_q <= disp_d;
  end

  assign disp_now = disp_q;
`else
  logic unused_lap;
  assign unused_lap = bus.lap;
  assign disp_now   = time_q;
  assign disp_d     = time_d;
`endif

  assign bus.hours        = disp_now.hours;
  assign bus.minutes      = disp_now.minutes;
  assign bus.seconds      = disp_now.seconds;
  assign bus.milliseconds = disp_now.ms;
  assign bus.running      = running_q;
  assign bus.overflow     = ovf_q;
  assign bus.update       = upd_q;

endmodule

// File: doc/chrono_counter.md
# chrono_counter

Stopwatch time base feeding the digit-drawing stage. Divides the system clock into a 1 ms tick and keeps the running time as binary hours/minutes/seconds/milliseconds, matching exactly the widths the image drawer consumes. Start/stop and clear come from debounced single-cycle button pulses. An optional lap hold freezes the displayed time while counting continues.

## Interface
- CLK_FREQ_HZ, 50_000_000: system clock frequency.
- TICK_DIV, CLK_FREQ_HZ/1000: clock cycles per millisecond tick; must be ≥2.
- HOURS_MAX, 9: last hours value before wrap (one display digit).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_stop  in  1  one-cycle pulse; toggles run/pause.
- clear  in  1  one-cycle pulse; zeroes time, stops counting.
- lap  in  1  one-cycle pulse; toggles display hold (LAP only).
- hours  out  4  displayed hours, 0..HOURS_MAX.
- minutes  out  6  displayed minutes, 0..59.
- seconds  out  6  displayed seconds, 0..59.
- milliseconds  out  10  displayed milliseconds, 0..999.
- running  out  1  high while counting.
- overflow  out  1  sticky; set when hours wraps HOURS_MAX→0.
- update  out  1  one-cycle pulse on every cycle the displayed time changes.

## Operation
- Reset: all outputs 0; state IDLE; prescaler 0.
- States: IDLE (time zero, stopped), RUN, PAUSE, LAP_HOLD (lap builds only).
- IDLE --start_stop--> RUN; RUN --start_stop--> PAUSE; PAUSE --start_stop--> RUN.
- LAP: RUN --lap--> LAP_HOLD; LAP_HOLD --lap--> RUN (display catches up); LAP_HOLD --start_stop--> PAUSE, display resyncs to internal time. lap ignored in IDLE/PAUSE.
- clear from any state: internal and displayed time 0, prescaler 0, overflow 0, state IDLE.
- Priority for coincident pulses: clear > start_stop > lap.
- Prescaler counts 0..TICK_DIV-1 only in RUN/LAP_HOLD; tick when at TICK_DIV-1, then returns to 0. Holds its value in PAUSE (sub-ms phase preserved).
- Carry chain on tick: ms 999→0 increments seconds; seconds 59→0 increments minutes; minutes 59→0 increments hours; hours HOURS_MAX→0 sets overflow. All in one cycle.
- running = 1 in RUN and LAP_HOLD.
- update pulses when displayed registers change (tick outside LAP_HOLD, lap release, clear from non-zero time); never in LAP_HOLD ticks.

## Timing
- All outputs registered; no combinational input→output path.
- start_stop sampled at edge k → running=1 after edge k; first tick at edge k+TICK_DIV (from prescaler 0).
- Tick at edge n → new time and update visible after edge n (zero added latency).
- clear at edge k → outputs 0 after edge k; a tick coinciding with clear is discarded.
- reset asserted mid-count → outputs 0 immediately, independent of clk.

## Configuration
- CHRONO_LAP_EN defined: lap port, LAP_HOLD state and separate display registers present.
- Undefined: lap port present but ignored; displayed time is the internal counter directly; LAP_HOLD never reached.

## Structure
- chrono_pkg: state enum, field widths (4/6/6/10), limits 59/999, default HOURS_MAX.
- Sub-module ms_tick_gen: prescaler with enable and synchronous clear, outputs one-cycle tick.

## Test plan
- TICK_DIV=10: reset, start_stop, run 10,000 cycles → time 0:00:01.000, running=1, 1000 update pulses.
- Preset near limits (run to 0:59:59.999) one more tick → 1:00:00.000 same cycle; at 9:59:59.999 → 0:00:00.000, overflow=1.
- Pause after 25 cycles (prescaler 5), wait 100, resume → next tick exactly 5 cycles later, ms=3.
- clear and start_stop same cycle while running → time 0, IDLE, running=0, overflow cleared.
- CHRONO_LAP_EN: lap at 0:00:00.050, run 30 ms → outputs stay 050, no update; lap again → outputs 080, one update.
- Assert reset mid-count between edges → all outputs 0 before next clk edge.
